serial_logic_unit: RTL and testbench
====================================

# serial_logic_unit

Parametrised successor of the 4/8-bit bit-serial logic processor core. Holds two WIDTH-bit operand registers A and B, loads them from a data bus, and on a start request applies one of eight bitwise logic functions serially, STEP bits per clock, routing results back into A and/or B. Function and route codes are latched at start, and completion is signalled by a done pulse. The unit sits beneath the board top level, which owns input synchronisers and hex display drivers; every input here is already synchronous to Clk and active-high.

## Interface
- WIDTH, 8, operand register width; must be ≥ 2.
- STEP, 1, bits processed per shift cycle; WIDTH % STEP == 0, checked by elaboration-time assertion.
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Ld_A  input  1  load A from Din; accepted only in IDLE.
- Ld_B  input  1  load B from Din; accepted only in IDLE.
- Start  input  1  level request to run one operation.
- Din  input  WIDTH  load data.
- F  input  3  function select: 000 AND, 001 OR, 010 XOR, 011 ones, 100 NAND, 101 NOR, 110 XNOR, 111 zeros.
- R  input  2  route select: 00 A←A, B←B; 01 A←A, B←f; 10 A←f, B←B; 11 A←B, B←A.
- A  output  WIDTH  register A contents.
- B  output  WIDTH  register B contents.
- Busy  output  1  high in SHIFT.
- Done  output  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE, HOLD.
- IDLE:
  - Ld_A/Ld_B load Din into A/B; both asserted loads both.
  - Any load takes priority over Start; Start is ignored in a cycle with a load.
  - Start (no load) latches F and R into f_q/r_q, clears cnt, and goes to SHIFT.
- SHIFT, each cycle:
  - a = A[STEP-1:0], b = B[STEP-1:0], y = f_q(a,b) bitwise.
  - A ← {srcA, A[WIDTH-1:STEP]} and B ← {srcB, B[WIDTH-1:STEP]}, where srcA/srcB are chosen by r_q from {a, b, y}.
  - cnt increments; after the N-th shift (N = WIDTH/STEP), go to DONE.
- Net result after N shifts:
  - R=00: A and B unchanged.
  - R=01: B = f(A,B).
  - R=10: A = f(A,B).
  - R=11: A and B swapped.
- DONE: Done=1 for one cycle; next state is HOLD if Start=1, else IDLE.
- HOLD: wait until Start=0, then IDLE. A held Start therefore runs exactly once.
- Ignored outside IDLE: Ld_A, Ld_B, Start. F and R changes after start have no effect.
- Reset (any time, including mid-SHIFT): A=0, B=0, cnt=0, f_q=000, r_q=00, state IDLE, Busy=0, Done=0. A partial operation is abandoned.

## Timing
- Start sampled high at edge k: Busy high from k to k+N; shifts occur on edges k+1 … k+N.
- Done high from edge k+N to k+N+1.
- Total latency Start→Done = N+1 cycles. A/B final at Done assertion.
- Loads: A/B update on the sampling edge and are visible the following cycle.
- cnt width is $clog2(N+1); no wrap occurs because the exit compare is cnt == N-1 at the final shift.

## Structure
- Package serial_logic_pkg:
  - func_e enum (F codes above), route_e enum (R codes above).
  - state_e enum {IDLE, SHIFT, DONE, HOLD}.
- Sub-module serial_slice: combinational, parametrised by STEP; inputs a, b, func, route; outputs srcA, srcB. Top holds registers, counter and FSM.

## Test plan
- WIDTH=8, STEP=1: load A=0x3C, B=0x0F; F=010, R=10; Start → Done 9 cycles later, A=0x33, B=0x0F, Busy high exactly 8 cycles.
- WIDTH=8, STEP=4: same operands, F=000, R=01 → Done after 3 cycles, A=0x3C, B=0x0C; then R=11 → A=0x0C, B=0x3C.
- Start held high for 30 cycles after Done → exactly one operation, FSM in HOLD until Start falls; a second Start pulse runs again.
- Mid-SHIFT, change F/R and pulse Ld_A with Din=0xFF → no effect; result matches the latched F/R.
- Assert Reset at shift 3 of 8 → A=B=0, Busy=0, Done never pulses; next load/start works normally.
- Ld_A, Ld_B, Start all high in IDLE with Din=0xA5 → A=B=0xA5, FSM stays IDLE; Start alone next cycle starts.

Source files
------------

// File: rtl/serial_logic_pkg.sv
// Shared types for the bit-serial logic unit: function/route codes, FSM states
// and the single-bit logic operation used by the serial slice.
package serial_logic_pkg;

  typedef enum logic [2:0] {
    F_AND   = 3'b000,
    F_OR    = 3'b001,
    F_XOR   = 3'b010,
    F_ONES  = 3'b011,
    F_NAND  = 3'b100,
    F_NOR   = 3'b101,
    F_XNOR  = 3'b110,
    F_ZEROS = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    R_KEEP = 2'b00,  // A<-A, B<-B
    R_TO_B = 2'b01,  // A<-A, B<-f
    R_TO_A = 2'b10,  // A<-f, B<-B
    R_SWAP = 2'b11   // A<-B, B<-A
  } route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    HOLD  = 2'b11
  } state_e;

  function automatic logic logic_op(input func_e f, input logic a, input logic b);
    logic y;
    case (f)
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_XOR:   y = a ^ b;
      F_ONES:  y = 1'b1;
      F_NAND:  y = ~(a & b);
      F_NOR:   y = ~(a | b);
      F_XNOR:  y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/serial_slice.sv
// Combinational STEP-bit slice: applies the latched logic function to the low
// bits of A and B and picks what gets shifted back into each register.
module serial_slice
  import serial_logic_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] i_a,
  input  logic [STEP-1:0] i_b,
  input  func_e           i_func,
  input  route_e          i_route,
  output logic [STEP-1:0] o_src_a,
  output logic [STEP-1:0] o_src_b
);

  logic [STEP-1:0] w_y;

  // Bitwise function result for this slice
  always_comb begin
    w_y = '0;
    for (int i = 0; i < STEP; i++) begin
      w_y[i] = logic_op(i_func, i_a[i], i_b[i]);
    end
  end

  // Route selection: recirculating a/b keeps a register intact after N shifts
  always_comb begin
    o_src_a = i_a;
    o_src_b = i_b;
    case (i_route)
      R_TO_B: o_src_b = w_y;
      R_TO_A: o_src_a = w_y;
      R_SWAP: begin
        o_src_a = i_b;
        o_src_b = i_a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: two operand registers processed STEP bits per clock,
// with function/route latched at start and a one-cycle done pulse.
//   state | meaning
//   IDLE  | accept loads or a start request
//   SHIFT | one STEP-bit slice processed per cycle, N cycles total
//   DONE  | single-cycle completion pulse
//   HOLD  | wait for Start to drop so a held request runs once
module serial_logic_unit
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ld_a,
  input  logic             i_ld_b,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  input  logic [2:0]       i_f,
  input  logic [1:0]       i_r,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_busy,
  output logic             o_done
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_err
    $error("serial_logic_unit: WIDTH must be >= 2 and a multiple of STEP");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  func_e            r_f;
  route_e           r_r;

  logic             w_load;
  logic             w_go;
  logic             w_last;
  logic [STEP-1:0]  w_src_a;
  logic [STEP-1:0]  w_src_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;

  assign w_load = i_ld_a | i_ld_b;
  assign w_go   = i_start & ~w_load;
  assign w_last = (r_cnt == CNT_LAST);

  serial_slice #(.STEP(STEP)) u_slice (
    .i_a     (r_a[STEP-1:0]),
    .i_b     (r_b[STEP-1:0]),
    .i_func  (r_f),
    .i_route (r_r),
    .o_src_a (w_src_a),
    .o_src_b (w_src_b)
  );

  if (STEP == WIDTH) begin : g_full
    assign w_a_nxt = w_src_a;
    assign w_b_nxt = w_src_b;
  end else begin : g_part
    assign w_a_nxt = {w_src_a, r_a[WIDTH-1:STEP]};
    assign w_b_nxt = {w_src_b, r_b[WIDTH-1:STEP]};
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = i_start ? HOLD : IDLE;
      HOLD:    if (!i_start) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state == SHIFT);
    o_done = (r_state == DONE);
  end

  // Operand registers, shift counter and latched function/route
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_f   <= F_AND;
      r_r   <= R_KEEP;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_ld_a) r_a <= i_din;
          if (i_ld_b) r_b <= i_din;
          if (w_go) begin
            r_f   <= func_e'(i_f);
            r_r   <= route_e'(i_r);
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= w_a_nxt;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: a STEP=1 and a STEP=4 instance driven with
// directed and random operations, checked against a word-level model.
module tb_serial_logic_unit;

  logic       clk;
  logic       rst     [2];
  logic       ld_a    [2];
  logic       ld_b    [2];
  logic       start   [2];
  logic [7:0] din     [2];
  logic [2:0] f       [2];
  logic [1:0] r       [2];
  logic [7:0] a_o     [2];
  logic [7:0] b_o     [2];
  logic       busy    [2];
  logic       done    [2];

  logic [7:0] ma      [2];
  logic [7:0] mb      [2];
  int         n_shift [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_logic_unit #(.WIDTH(8), .STEP(1)) u_s1 (
    .i_clk(clk), .i_reset(rst[0]), .i_ld_a(ld_a[0]), .i_ld_b(ld_b[0]),
    .i_start(start[0]), .i_din(din[0]), .i_f(f[0]), .i_r(r[0]),
    .o_a(a_o[0]), .o_b(b_o[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  serial_logic_unit #(.WIDTH(8), .STEP(4)) u_s4 (
    .i_clk(clk), .i_reset(rst[1]), .i_ld_a(ld_a[1]), .i_ld_b(ld_b[1]),
    .i_start(start[1]), .i_din(din[1]), .i_f(f[1]), .i_r(r[1]),
    .o_a(a_o[1]), .o_b(b_o[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: whole-operand function, then routing
  task automatic ref_op(input logic [2:0] fv, input logic [1:0] rv,
                        input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] na, output logic [7:0] nb);
    logic [7:0] y;
    case (fv)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = 8'hFF;
      3'd4: y = ~(a & b);
      3'd5: y = ~(a | b);
      3'd6: y = ~(a ^ b);
      default: y = 8'h00;
    endcase
    na = a; nb = b;
    case (rv)
      2'd1: nb = y;
      2'd2: na = y;
      2'd3: begin na = b; nb = a; end
      default: ;
    endcase
  endtask

  task automatic load(input int d, input bit la, input bit lb, input logic [7:0] v);
    @(negedge clk);
    ld_a[d] = la; ld_b[d] = lb; din[d] = v; start[d] = 1'b0;
    @(negedge clk);
    ld_a[d] = 1'b0; ld_b[d] = 1'b0;
    if (la) ma[d] = v;
    if (lb) mb[d] = v;
    chk($sformatf("load_a d%0d", d), a_o[d], ma[d]);
    chk($sformatf("load_b d%0d", d), b_o[d], mb[d]);
  endtask

  task automatic run_op(input int d, input logic [2:0] fv, input logic [1:0] rv,
                        input bit hold, input bit perturb, input string tag);
    logic [7:0] ea, eb;
    int nb, di, nd;
    @(negedge clk);
    start[d] = 1'b1; f[d] = fv; r[d] = rv; ld_a[d] = 1'b0; ld_b[d] = 1'b0;
    ref_op(fv, rv, ma[d], mb[d], ea, eb);
    nb = 0; di = 0; nd = 0;
    for (int i = 1; i <= n_shift[d] + 4; i++) begin
      @(negedge clk);
      if (busy[d]) nb++;
      if (done[d]) begin
        nd++;
        if (di == 0) di = i;
        chk({tag, " a_at_done"}, a_o[d], ea);
        chk({tag, " b_at_done"}, b_o[d], eb);
      end
      if (!hold) start[d] = 1'b0;
      if (perturb && i == 2) begin
        f[d] = ~fv; r[d] = ~rv; ld_a[d] = 1'b1; din[d] = 8'hFF;
      end
      if (perturb && i == 3) ld_a[d] = 1'b0;
    end
    chk({tag, " busy_cycles"}, nb, n_shift[d]);
    chk({tag, " done_index"}, di, n_shift[d] + 1);
    chk({tag, " done_count"}, nd, 1);
    chk({tag, " a_final"}, a_o[d], ea);
    chk({tag, " b_final"}, b_o[d], eb);
    ma[d] = ea; mb[d] = eb;
  endtask

  initial begin
    int extra;
    n_shift[0] = 8; n_shift[1] = 2;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ld_a[d] = 1'b0; ld_b[d] = 1'b0; start[d] = 1'b0;
      din[d] = 8'h00; f[d] = 3'd0; r[d] = 2'd0; ma[d] = 8'h00; mb[d] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_a d%0d", d), a_o[d], 8'h00);
      chk($sformatf("reset_b d%0d", d), b_o[d], 8'h00);
      chk($sformatf("reset_busy d%0d", d), busy[d], 1'b0);
      chk($sformatf("reset_done d%0d", d), done[d], 1'b0);
      rst[d] = 1'b0;
    end

    // XOR into A, one bit per cycle
    load(0, 1, 0, 8'h3C);
    load(0, 0, 1, 8'h0F);
    run_op(0, 3'b010, 2'b10, 0, 0, "s1_xor_toA");
    chk("s1_xor_a_const", a_o[0], 8'h33);
    chk("s1_xor_b_const", b_o[0], 8'h0F);

    // AND into B, then swap, four bits per cycle
    load(1, 1, 0, 8'h3C);
    load(1, 0, 1, 8'h0F);
    run_op(1, 3'b000, 2'b01, 0, 0, "s4_and_toB");
    chk("s4_and_a_const", a_o[1], 8'h3C);
    chk("s4_and_b_const", b_o[1], 8'h0C);
    run_op(1, 3'b000, 2'b11, 0, 0, "s4_swap");
    chk("s4_swap_a_const", a_o[1], 8'h0C);
    chk("s4_swap_b_const", b_o[1], 8'h3C);

    // Held Start runs once, then a fresh request runs again
    run_op(1, 3'b001, 2'b10, 1, 0, "s4_hold");
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy[1] || done[1]) extra++;
    end
    chk("hold_no_rerun", extra, 0);
    start[1] = 1'b0;
    @(negedge clk);
    run_op(1, 3'b110, 2'b01, 0, 0, "s4_after_hold");

    // Mid-shift changes to F/R and a load attempt are ignored
    load(0, 1, 1, 8'h96);
    load(0, 0, 1, 8'h5A);
    run_op(0, 3'b101, 2'b01, 0, 1, "s1_perturb");
    load(1, 1, 0, 8'hE1);
    run_op(1, 3'b100, 2'b10, 0, 1, "s4_perturb");

    // Reset in the middle of a shift abandons the operation
    load(0, 1, 0, 8'h5A);
    load(0, 0, 1, 8'hC3);
    @(negedge clk);
    start[0] = 1'b1; f[0] = 3'b000; r[0] = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midreset_a", a_o[0], 8'h00);
    chk("midreset_b", b_o[0], 8'h00);
    chk("midreset_busy", busy[0], 1'b0);
    rst[0] = 1'b0;
    ma[0] = 8'h00; mb[0] = 8'h00;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done[0] || busy[0]) extra++;
    end
    chk("midreset_no_done", extra, 0);
    load(0, 1, 0, 8'h71);
    load(0, 0, 1, 8'h2E);
    run_op(0, 3'b110, 2'b10, 0, 0, "s1_after_reset");

    // Loads take priority over a simultaneous Start
    @(negedge clk);
    ld_a[0] = 1'b1; ld_b[0] = 1'b1; start[0] = 1'b1; din[0] = 8'hA5;
    @(negedge clk);
    ld_a[0] = 1'b0; ld_b[0] = 1'b0; start[0] = 1'b0;
    ma[0] = 8'hA5; mb[0] = 8'hA5;
    chk("ldstart_a", a_o[0], 8'hA5);
    chk("ldstart_b", b_o[0], 8'hA5);
    chk("ldstart_idle", busy[0], 1'b0);
    run_op(0, 3'b011, 2'b01, 0, 0, "s1_after_ldstart");

    // Random loads and operations on both instances
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] fv;
        logic [1:0] rv;
        int sel;
        sel = $urandom_range(0, 3);
        if (sel != 0) load(d, sel[0], sel[1], 8'($urandom));
        fv = 3'($urandom);
        rv = 2'($urandom);
        run_op(d, fv, rv, 0, ($urandom_range(0, 3) == 0),
               $sformatf("rand%0d_d%0d_f%0d_r%0d", k, d, fv, rv));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
